// File: rtl/mips_cpu_lsu_if.sv
// Request/response and data-memory signals of the MIPS load/store unit.
// slave: the LSU itself; master: the execute stage plus data memory around it.
interface mips_cpu_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] data_address;
   logic        data_write;
   logic        data_read;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, data_readdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             data_address, data_write, data_read, data_writedata
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, data_readdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             data_address, data_write, data_read, data_writedata
   );
endinterface

// File: rtl/mips_cpu_lsu.sv
// Load/store unit driving a word-wide, combinational-read data memory.
// Sub-word stores are done as read-modify-write since the memory has no byte enables.
module mips_cpu_lsu #(
   parameter bit ALIGN_CHECK = 1'b1,
   parameter bit LITTLE_END  = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   mips_cpu_lsu_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR} state_t;

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LBU = 3'd1;
   localparam logic [2:0] OP_LH  = 3'd2;
   localparam logic [2:0] OP_LHU = 3'd3;
   localparam logic [2:0] OP_LW  = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merge_q, merge_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

   function automatic logic [4:0] byte_shift(input logic [1:0] idx);
      return LITTLE_END ? {idx, 3'b000} : (5'd24 - {idx, 3'b000});
   endfunction

   function automatic logic [4:0] half_shift(input logic hsel);
      return (LITTLE_END ? hsel : ~hsel) ? 5'd16 : 5'd0;
   endfunction

   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
      case (op)
         OP_LH, OP_LHU, OP_SH: return lo[0];
         OP_LW, OP_SW:         return (lo != 2'b00);
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] extract_load(input logic [2:0] op, input logic [1:0] lo,
                                                input logic [31:0] word);
      logic [31:0] lane;
      case (op)
         OP_LB, OP_LBU: begin
            lane = word >> byte_shift(lo);
            return (op == OP_LB) ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
         end
         OP_LH, OP_LHU: begin
            lane = word >> half_shift(lo[1]);
            return (op == OP_LH) ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
         end
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] merge_store(input logic [2:0] op, input logic [1:0] lo,
                                               input logic [31:0] old, input logic [31:0] wd);
      logic [4:0]  sh;
      logic [31:0] mask;
      logic [31:0] ins;
      if (op == OP_SB) begin
         sh   = byte_shift(lo);
         mask = 32'h0000_00FF << sh;
         ins  = {24'b0, wd[7:0]} << sh;
      end else begin
         sh   = half_shift(lo[1]);
         mask = 32'h0000_FFFF << sh;
         ins  = {16'b0, wd[15:0]} << sh;
      end
      return (old & ~mask) | ins;
   endfunction

   always_comb begin
      state_d             = state_q;
      op_d                = op_q;
      addr_d              = addr_q;
      wdata_d             = wdata_q;
      merge_d             = merge_q;
      rsp_valid_d         = 1'b0;
      rsp_err_d           = rsp_err_q;
      rsp_rdata_d         = rsp_rdata_q;
      bus.req_ready       = 1'b0;
      bus.data_read       = 1'b0;
      bus.data_write      = 1'b0;
      bus.data_address    = 32'b0;
      bus.data_writedata  = 32'b0;

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               op_d    = bus.req_op;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               if (ALIGN_CHECK && misaligned(bus.req_op, bus.req_addr[1:0]))
                  state_d = ERR;
               else if (bus.req_op <= OP_LW)
                  state_d = LOAD;
               else if (bus.req_op == OP_SW)
                  state_d = STORE;
               else
                  state_d = RMW_RD;
            end
         end
         LOAD: begin
            bus.data_read    = 1'b1;
            bus.data_address = {addr_q[31:2], 2'b00};
            rsp_rdata_d      = extract_load(op_q, addr_q[1:0], bus.data_readdata);
            rsp_err_d        = 1'b0;
            rsp_valid_d      = 1'b1;
            state_d          = IDLE;
         end
         STORE: begin
            bus.data_write     = 1'b1;
            bus.data_address   = {addr_q[31:2], 2'b00};
            bus.data_writedata = wdata_q;
            rsp_rdata_d        = 32'b0;
            rsp_err_d          = 1'b0;
            rsp_valid_d        = 1'b1;
            state_d            = IDLE;
         end
         RMW_RD: begin
            // Read data is only trusted here, so x from an idle memory never reaches merge_q.
            bus.data_read    = 1'b1;
            bus.data_address = {addr_q[31:2], 2'b00};
            merge_d          = bus.data_readdata;
            state_d          = RMW_WR;
         end
         RMW_WR: begin
            bus.data_write     = 1'b1;
            bus.data_address   = {addr_q[31:2], 2'b00};
            bus.data_writedata = merge_store(op_q, addr_q[1:0], merge_q, wdata_q);
            rsp_rdata_d        = 32'b0;
            rsp_err_d          = 1'b0;
            rsp_valid_d        = 1'b1;
            state_d            = IDLE;
         end
         ERR: begin
            rsp_rdata_d = 32'b0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Request payload and merge word are only read in states that wrote them first.
   always_ff @(posedge clk) begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Randomized self-checking bench for mips_cpu_lsu against a byte-addressed memory model.
module tb_mips_cpu_lsu;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mips_cpu_lsu_if bus ();

   mips_cpu_lsu #(.ALIGN_CHECK(1'b1), .LITTLE_END(1'b1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [31:0] mem [0:1023];
   logic [7:0]  ref_bytes [0:4095];
   logic        poke_en;
   logic [9:0]  poke_idx;
   logic [31:0] poke_val;
   int          cyc = 0;
   int          rd_total = 0;
   int          wr_total = 0;
   bit          viol = 1'b0;
   int          n_chk = 0;
   int          n_pass = 0;

   assign bus.data_readdata = bus.data_read ? mem[bus.data_address[11:2]] : 'x;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (poke_en)
         mem[poke_idx] <= poke_val;
      else if (bus.data_write && !bus.data_read)
         mem[bus.data_address[11:2]] <= bus.data_writedata;
   end

   always @(negedge clk) begin
      if (bus.data_read) rd_total++;
      if (bus.data_write) wr_total++;
      if (bus.data_read && bus.data_write) viol = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
      int base;
      base     = int'(addr[11:0]) & ~3;
      poke_en  = 1'b1;
      poke_idx = addr[11:2];
      poke_val = val;
      for (int k = 0; k < 4; k++) ref_bytes[base + k] = val[8*k +: 8];
      @(posedge clk);
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Called on a negedge while the LSU is idle; returns on the response negedge.
   task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input bit hold, output logic [31:0] rd, output int acc);
      logic [31:0] exp_rd;
      logic [15:0] h;
      bit          mis;
      int          a, w, lat, rd0, wr0, exp_lat, exp_nrd, exp_nwr;
      a = int'(addr[11:0]);
      case (op)
         3'd2, 3'd3, 3'd6: mis = addr[0];
         3'd4, 3'd7:       mis = (addr[1:0] != 2'b00);
         default:          mis = 1'b0;
      endcase
      exp_rd = 32'b0; exp_lat = 2; exp_nrd = 0; exp_nwr = 0;
      if (!mis) begin
         case (op)
            3'd0: begin exp_rd = {{24{ref_bytes[a][7]}}, ref_bytes[a]}; exp_nrd = 1; end
            3'd1: begin exp_rd = {24'b0, ref_bytes[a]}; exp_nrd = 1; end
            3'd2: begin h = {ref_bytes[a+1], ref_bytes[a]}; exp_rd = {{16{h[15]}}, h}; exp_nrd = 1; end
            3'd3: begin h = {ref_bytes[a+1], ref_bytes[a]}; exp_rd = {16'b0, h}; exp_nrd = 1; end
            3'd4: begin
               exp_rd  = {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
               exp_nrd = 1;
            end
            3'd5: begin ref_bytes[a] = wd[7:0]; exp_lat = 3; exp_nrd = 1; exp_nwr = 1; end
            3'd6: begin
               ref_bytes[a] = wd[7:0]; ref_bytes[a+1] = wd[15:8];
               exp_lat = 3; exp_nrd = 1; exp_nwr = 1;
            end
            default: begin
               for (int k = 0; k < 4; k++) ref_bytes[a+k] = wd[8*k +: 8];
               exp_nwr = 1;
            end
         endcase
      end

      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      rd0 = rd_total;
      wr0 = wr_total;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      @(posedge clk);
      #1;
      acc = cyc;
      if (!hold) begin
         bus.req_valid = 1'b0;
         bus.req_op    = 3'($urandom_range(0, 7));
         bus.req_addr  = $urandom;
         bus.req_wdata = $urandom;
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rsp_valid && lat < 10);
      if (!bus.rsp_valid) lat = 99;

      chk($sformatf("latency op%0d", op), lat, exp_lat);
      chk($sformatf("rdata op%0d a%h", op, addr), bus.rsp_rdata, exp_rd);
      chk($sformatf("err op%0d a%h", op, addr), 32'(bus.rsp_err), 32'(mis));
      chk($sformatf("reads op%0d", op), rd_total - rd0, exp_nrd);
      chk($sformatf("writes op%0d", op), wr_total - wr0, exp_nwr);
      w = a >> 2;
      chk($sformatf("memword %h", w * 4), mem[w],
          {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]});
      chk("req_ready_rsp", 32'(bus.req_ready), 32'd1);
      rd = bus.rsp_rdata;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int          acc1, acc2;
      logic [2:0]  op;
      logic [31:0] addr;
      bit          hold;

      reset_n       = 1'b0;
      poke_en       = 1'b0;
      poke_idx      = '0;
      poke_val      = '0;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_data_read", 32'(bus.data_read), 32'd0);
      chk("rst_data_write", 32'(bus.data_write), 32'd0);
      chk("rst_data_address", bus.data_address, 32'd0);
      chk("rst_data_writedata", bus.data_writedata, 32'd0);

      for (int i = 0; i < 1024; i++) set_word(32'(i * 4), $urandom);
      reset_n = 1'b1;
      @(negedge clk);

      set_word(32'h100, 32'h8000_80F0);
      do_req(3'd0, 32'h100, 32'h0, 1'b0, rd, acc1);
      chk("LB_0x100", rd, 32'hFFFF_FFF0);
      do_req(3'd1, 32'h100, 32'h0, 1'b0, rd, acc1);
      chk("LBU_0x100", rd, 32'h0000_00F0);
      do_req(3'd2, 32'h102, 32'h0, 1'b0, rd, acc1);
      chk("LH_0x102", rd, 32'hFFFF_8000);

      do_req(3'd7, 32'h200, 32'hDEAD_BEEF, 1'b1, rd, acc1);
      do_req(3'd4, 32'h200, 32'h0, 1'b0, rd, acc2);
      chk("LW_after_SW", rd, 32'hDEAD_BEEF);
      chk("b2b_accept_gap", acc2 - acc1, 32'd2);

      set_word(32'h300, 32'h1122_3344);
      do_req(3'd5, 32'h301, 32'h0000_00AA, 1'b0, rd, acc1);
      chk("SB_0x301", mem[10'h0C0], 32'h1122_AA44);
      do_req(3'd6, 32'h302, 32'h0000_5566, 1'b0, rd, acc1);
      chk("SH_0x302", mem[10'h0C0], 32'h5566_AA44);

      do_req(3'd4, 32'h203, 32'h0, 1'b0, rd, acc1);
      chk("LW_0x203_rdata", rd, 32'h0);
      do_req(3'd6, 32'h305, 32'hFFFF_FFFF, 1'b0, rd, acc1);
      chk("SH_0x305_rdata", rd, 32'h0);

      do_req(3'd4, 32'h300, 32'h0, 1'b0, rd, acc1);
      chk("LW_0x300", rd, 32'h5566_AA44);

      // Reset asserted while an SB sits in its read phase.
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd5;
      bus.req_addr  = 32'h301;
      bus.req_wdata = 32'h77;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("rmw_rd_active", 32'(bus.data_read), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_data_read", 32'(bus.data_read), 32'd0);
      chk("mid_rst_data_write", 32'(bus.data_write), 32'd0);
      chk("mid_rst_data_address", bus.data_address, 32'd0);
      chk("mid_rst_data_writedata", bus.data_writedata, 32'd0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_mem_unchanged", mem[10'h0C0], 32'h5566_AA44);
      chk("mid_rst_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);

      for (int t = 0; t < 400; t++) begin
         op   = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
         hold = (t != 399) && ($urandom_range(0, 3) == 0);
         do_req(op, addr, $urandom, hold, rd, acc1);
         if (!hold && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            chk("rsp_single_pulse", 32'(bus.rsp_valid), 32'd0);
         end
      end

      chk("read_write_exclusive", 32'(viol), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
